updown_counter: RTL and testbench
=================================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, 2..32.
REQ-002 Parameter MIN_VALUE, default 0: lowest legal count.
REQ-003 Parameter MAX_VALUE, default 2**WIDTH-1: highest legal count, MIN_VALUE < MAX_VALUE <= 2**WIDTH-1.
REQ-004 Parameter RESET_VALUE, default MIN_VALUE: count after reset or clear, within [MIN_VALUE, MAX_VALUE].
REQ-005 Parameter ROLLOVER_VALUE, default MIN_VALUE: wrap target on up-count overflow, within [MIN_VALUE, MAX_VALUE].
REQ-006 Parameter ROLLUNDER_VALUE, default MAX_VALUE: wrap target on down-count underflow, within [MIN_VALUE, MAX_VALUE].
REQ-007 Parameter STEP, default 1: increment per enabled cycle; 1 <= STEP <= MAX_VALUE-ROLLOVER_VALUE+1 and STEP <= ROLLUNDER_VALUE-MIN_VALUE+1.
REQ-008 Parameter SATURATE, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-009 clk  input  1  sole clock; all state updates on its rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 enable  input  1  count by STEP this cycle.
REQ-012 up  input  1  direction: 1 = up, 0 = down.
REQ-013 clear  input  1  synchronous return to RESET_VALUE.
REQ-014 load  input  1  synchronous load of load_value.
REQ-015 load_value  input  WIDTH  value captured when load is high.
REQ-016 cnt  output  WIDTH  registered count.
REQ-017 rollover  output  1  registered one-cycle pulse: an up-wrap occurred on the previous edge.
REQ-018 rollunder  output  1  registered one-cycle pulse: a down-wrap occurred on the previous edge.
REQ-019 at_max  output  1  combinational: cnt == MAX_VALUE.
REQ-020 at_min  output  1  combinational: cnt == MIN_VALUE.

Function
REQ-021 Per-edge priority SHALL be clear > load > enable > hold.
REQ-022 On load, cnt SHALL take load_value clamped to [MIN_VALUE, MAX_VALUE]; rollover/rollunder SHALL be 0 next cycle.
REQ-023 Up-count: if cnt+STEP <= MAX_VALUE, next = cnt+STEP; otherwise, next = cnt+STEP-(MAX_VALUE-ROLLOVER_VALUE+1) and rollover pulses.
REQ-024 Down-count: if cnt >= MIN_VALUE+STEP, next = cnt-STEP; otherwise, next = cnt-STEP+(ROLLUNDER_VALUE-MIN_VALUE+1) and rollunder pulses.
REQ-025 Overflow/underflow comparisons SHALL use WIDTH+1-bit intermediates, so that no comparison is lost to truncation at MAX_VALUE = 2**WIDTH-1.
REQ-026 SATURATE=1: up-count past MAX_VALUE SHALL yield MAX_VALUE, down-count past MIN_VALUE SHALL yield MIN_VALUE; rollover/rollunder SHALL be tied 0.
REQ-027 cnt SHALL change only on the clk edge where clear, load or enable is sampled high; latency is one edge.
REQ-028 rollover and rollunder SHALL never be high simultaneously and SHALL be high for exactly one cycle per wrap.
REQ-029 With enable held high across consecutive wraps, one pulse SHALL be produced per wrap.
REQ-030 Elaboration SHALL fail via $error on any parameter range violation in REQ-001..REQ-008.

Reset
REQ-031 While reset is high, cnt SHALL equal RESET_VALUE and rollover = rollunder = 0, independent of clk.
REQ-032 Reset asserted mid-count SHALL take effect immediately; the first update after release SHALL be on the first rising edge with reset low.
REQ-033 If cnt sits at MAX_VALUE when reset is applied, no rollover pulse SHALL follow reset release.

Verification
REQ-034 WIDTH=4, defaults, up=1, enable high 20 cycles after reset -> cnt 0..15,0,1,2,3; rollover high only in the cycle cnt=0 after 15.
REQ-035 WIDTH=8, MIN=0, MAX=220, RESET=200, ROLLOVER=210, up=1, enable 40 cycles -> 200..220,210..220,210..217; rollover after each 220->210.
REQ-036 WIDTH=8, defaults, up=0, STEP=3, start 4 -> cnt 4,1,254,251; rollunder high only in the cycle cnt=254.
REQ-037 SATURATE=1, WIDTH=4, STEP=4, load 13 then up -> 13,15,15; then down from 2 -> 2,0,0; rollover and rollunder never asserted.
REQ-038 clear, load (load_value=9) and enable high on the same edge -> cnt=RESET_VALUE; load with load_value=250 and MAX=220 -> cnt=220.
REQ-039 Reset pulsed asynchronously between edges while counting at cnt=7 -> cnt=RESET_VALUE immediately; counting resumes from RESET_VALUE on the first edge after release.

Source files
------------

// File: rtl/updown_counter.sv
// Parameterised up/down counter with independent wrap targets for overflow
// and underflow, optional saturation, synchronous clear/load and registered
// one-cycle wrap pulses.
module updown_counter #(
    parameter int     WIDTH           = 8,
    parameter longint MIN_VALUE       = 0,
    parameter longint MAX_VALUE       = (longint'(1) << WIDTH) - 1,
    parameter longint RESET_VALUE     = MIN_VALUE,
    parameter longint ROLLOVER_VALUE  = MIN_VALUE,
    parameter longint ROLLUNDER_VALUE = MAX_VALUE,
    parameter longint STEP            = 1,
    parameter bit     SATURATE        = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] cnt,
    output logic             rollover,
    output logic             rollunder,
    output logic             at_max,
    output logic             at_min
);

    // Parameter legality is checked at elaboration so a bad configuration
    // never reaches synthesis.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter: WIDTH must be in 2..32");
    end
    if (MIN_VALUE < 0 || MAX_VALUE <= MIN_VALUE ||
        MAX_VALUE > (longint'(1) << WIDTH) - 1) begin : g_bad_range
        $error("updown_counter: need 0 <= MIN_VALUE < MAX_VALUE <= 2**WIDTH-1");
    end
    if (RESET_VALUE < MIN_VALUE || RESET_VALUE > MAX_VALUE ||
        ROLLOVER_VALUE < MIN_VALUE || ROLLOVER_VALUE > MAX_VALUE ||
        ROLLUNDER_VALUE < MIN_VALUE || ROLLUNDER_VALUE > MAX_VALUE) begin : g_bad_target
        $error("updown_counter: reset/rollover/rollunder values must lie in [MIN_VALUE, MAX_VALUE]");
    end
    if (STEP < 1 || STEP > MAX_VALUE - ROLLOVER_VALUE + 1 ||
        STEP > ROLLUNDER_VALUE - MIN_VALUE + 1) begin : g_bad_step
        $error("updown_counter: STEP out of range for the wrap spans");
    end

    // Wrap spans: how far a wrap moves the count back (up) or forward (down).
    localparam longint SPAN_UP = MAX_VALUE - ROLLOVER_VALUE + 1;
    localparam longint SPAN_DN = ROLLUNDER_VALUE - MIN_VALUE + 1;

    // Comparison constants are one bit wider than the count so that
    // cnt+STEP is never truncated when MAX_VALUE = 2**WIDTH-1.
    localparam logic [WIDTH:0] MAX_X    = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0] STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] DN_THR_X = (WIDTH+1)'(MIN_VALUE + STEP);

    // Result constants: wrapped results always land in range, so modular
    // WIDTH-bit arithmetic gives the exact value.
    localparam logic [WIDTH-1:0] MIN_N      = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_N      = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RESET_N    = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] STEP_N     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] UP_WRAP_N  = WIDTH'(STEP - SPAN_UP);
    localparam logic [WIDTH-1:0] DN_WRAP_N  = WIDTH'(SPAN_DN - STEP);

    logic [WIDTH:0]   up_sum;
    logic             up_over;
    logic             dn_under;
    logic [WIDTH-1:0] cnt_next;
    logic             rollover_next;
    logic             rollunder_next;

    // Next-count selection: clear > load > enable > hold.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        cnt_next       = cnt;
        rollover_next  = 1'b0;
        rollunder_next = 1'b0;
        up_sum         = {1'b0, cnt} + STEP_X;
        up_over        = (up_sum > MAX_X);
        dn_under       = ({1'b0, cnt} < DN_THR_X);

        if (clear) begin
            cnt_next = RESET_N;
        end else if (load) begin
            if (load_value < MIN_N)
                cnt_next = MIN_N;
            else if (load_value > MAX_N)
                cnt_next = MAX_N;
            else
                cnt_next = load_value;
        end else if (enable) begin
            if (up) begin
                if (!up_over)
                    cnt_next = cnt + STEP_N;
                else if (SATURATE)
                    cnt_next = MAX_N;
                else begin
                    cnt_next      = cnt + UP_WRAP_N;
                    rollover_next = 1'b1;
                end
            end else begin
                if (!dn_under)
                    cnt_next = cnt - STEP_N;
                else if (SATURATE)
                    cnt_next = MIN_N;
                else begin
                    cnt_next       = cnt + DN_WRAP_N;
                    rollunder_next = 1'b1;
                end
            end
        end
    end

    // Count and wrap-pulse registers; reset forces the idle state at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            cnt       <= RESET_N;
            rollover  <= 1'b0;
            rollunder <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            rollover  <= rollover_next;
            rollunder <= rollunder_next;
        end
    end

    // Boundary flags follow the current count directly.
    assign at_max = (cnt == MAX_N);
    assign at_min = (cnt == MIN_N);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: four configurations share one set of
// stimulus signals; each phase checks the instance it targets.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up;
    logic       clear;
    logic       load;
    logic [7:0] load_value;

    logic [3:0] cnt0, cnt3;
    logic [7:0] cnt1, cnt2;
    logic ro0, ru0, amax0, amin0;
    logic ro1, ru1, amax1, amin1;
    logic ro2, ru2, amax2, amin2;
    logic ro3, ru3, amax3, amin3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // WIDTH=4, all defaults.
    updown_counter #(.WIDTH(4)) d0 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value[3:0]), .cnt(cnt0),
        .rollover(ro0), .rollunder(ru0), .at_max(amax0), .at_min(amin0));

    // WIDTH=8, range 0..220, reset 200, wrap-up target 210.
    updown_counter #(.WIDTH(8), .MIN_VALUE(0), .MAX_VALUE(220),
                     .RESET_VALUE(200), .ROLLOVER_VALUE(210)) d1 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .cnt(cnt1),
        .rollover(ro1), .rollunder(ru1), .at_max(amax1), .at_min(amin1));

    // WIDTH=8, full range, STEP=3.
    updown_counter #(.WIDTH(8), .STEP(3)) d2 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .cnt(cnt2),
        .rollover(ro2), .rollunder(ru2), .at_max(amax2), .at_min(amin2));

    // WIDTH=4, STEP=4, saturating.
    updown_counter #(.WIDTH(4), .STEP(4), .SATURATE(1'b1)) d3 (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value[3:0]), .cnt(cnt3),
        .rollover(ro3), .rollunder(ru3), .at_max(amax3), .at_min(amin3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        logic exp_ro;

        reset = 1'b1; enable = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = 8'd0;

        // Reset state.
        step(); step();
        check("reset_cnt0", cnt0, 0);
        check("reset_ro0", ro0, 0);
        check("reset_ru0", ru0, 0);
        check("reset_cnt1", cnt1, 200);
        check("reset_at_min0", amin0, 1);

        // 4-bit up count over a wrap: 0..15,0,1,2,3.
        reset = 1'b0; enable = 1'b1; up = 1'b1;
        for (int k = 1; k < 20; k++) begin
            step();
            check("w4_cnt", cnt0, k % 16);
            check("w4_ro", ro0, (k == 16) ? 1 : 0);
            check("w4_ru", ru0, 0);
            if (k == 15) check("w4_at_max", amax0, 1);
        end

        // Async reset between edges at cnt=7; resume from reset value.
        repeat (4) step();
        check("mid_cnt7", cnt0, 7);
        #2 reset = 1'b1;
        #1 check("async_cnt", cnt0, 0);
        check("async_ro", ro0, 0);
        reset = 1'b0;
        step();
        check("resume_cnt", cnt0, 1);

        // Reset while at MAX: no rollover pulse afterwards.
        enable = 1'b0; load = 1'b1; load_value = 8'd15;
        step();
        check("atmax_cnt", cnt0, 15);
        check("atmax_flag", amax0, 1);
        load = 1'b0;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        step();
        check("post_rst_ro", ro0, 0);
        check("post_rst_cnt", cnt0, 0);

        // Custom range: 200..220, then 210..220 cycles.
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        enable = 1'b1; up = 1'b1;
        check("cr_start", cnt1, 200);
        v = 200;
        for (int k = 1; k < 40; k++) begin
            exp_ro = (v == 220);
            v = exp_ro ? 210 : v + 1;
            step();
            check("cr_cnt", cnt1, v);
            check("cr_ro", ro1, exp_ro);
        end
        check("cr_end", cnt1, 217);

        // Priority: clear beats load and enable; load clamps to MAX.
        clear = 1'b1; load = 1'b1; load_value = 8'd9; enable = 1'b1;
        step();
        check("prio_cnt", cnt1, 200);
        check("prio_ro", ro1, 0);
        clear = 1'b0; load_value = 8'd250;
        step();
        check("clamp_cnt", cnt1, 220);
        check("clamp_at_max", amax1, 1);

        // STEP=3 down count through underflow: 4,1,254,251.
        enable = 1'b0; load_value = 8'd4;
        step();
        check("dn_start", cnt2, 4);
        load = 1'b0; up = 1'b0; enable = 1'b1;
        step();
        check("dn_cnt1", cnt2, 1);
        check("dn_ru1", ru2, 0);
        step();
        check("dn_cnt254", cnt2, 254);
        check("dn_ru254", ru2, 1);
        check("dn_ro254", ro2, 0);
        step();
        check("dn_cnt251", cnt2, 251);
        check("dn_ru251", ru2, 0);

        // Full-range up wrap past 2**WIDTH-1: 254+3 -> 1.
        enable = 1'b0; load = 1'b1; load_value = 8'd254; up = 1'b1;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        check("full_wrap_cnt", cnt2, 1);
        check("full_wrap_ro", ro2, 1);
        enable = 1'b0;

        // Saturating: 13,15,15 up; 2,0,0 down; no pulses; hold when idle.
        load = 1'b1; load_value = 8'd13;
        step();
        check("sat_load", cnt3, 13);
        load = 1'b0; enable = 1'b1; up = 1'b1;
        step();
        check("sat_up1", cnt3, 15);
        check("sat_up1_ro", ro3, 0);
        step();
        check("sat_up2", cnt3, 15);
        check("sat_up2_ro", ro3, 0);
        check("sat_at_max", amax3, 1);
        enable = 1'b0; load = 1'b1; load_value = 8'd2;
        step();
        check("sat_load2", cnt3, 2);
        load = 1'b0; enable = 1'b1; up = 1'b0;
        step();
        check("sat_dn1", cnt3, 0);
        check("sat_dn1_ru", ru3, 0);
        step();
        check("sat_dn2", cnt3, 0);
        check("sat_dn2_ru", ru3, 0);
        check("sat_at_min", amin3, 1);
        enable = 1'b0; up = 1'b1;
        step();
        check("sat_hold", cnt3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
